vga_frame_capture: RTL and testbench

//  Receive end of the 640x480 VGA link driven by the 8x8 display driver. Recovers raster

---
 rtl/vga_timing_pkg.sv | 36 +++
 rtl/vga_sync_tracker.sv | 84 ++++++++
 rtl/vga_frame_capture.sv | 104 ++++++++++
 tb/tb_vga_frame_capture.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster constants, pixel type and helpers for the VGA display/capture pair.
package vga_timing_pkg;

  localparam int HPIXELS     = 800;
  localparam int VLINES      = 521;
  localparam int HPULSE      = 96;
  localparam int VPULSE      = 2;
  localparam int HBP         = 144;
  localparam int HFP         = 16;
  localparam int VBP         = 31;
  localparam int VFP         = 10;
  localparam int CELL_W      = 80;
  localparam int CELL_H      = 60;
  localparam int LUM_THRESH  = 12;
  localparam int LOCK_FRAMES = 2;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } pixel_t;

  // Blue carries one bit less than red/green, so it is doubled to weigh equally.
  function automatic logic [4:0] luminance(pixel_t p);
    return 5'(p.r) + 5'(p.g) + 5'({p.b, 1'b0});
  endfunction

  function automatic logic [5:0] cell_idx(logic [2:0] x, logic [2:0] y);
    return {y, x};
  endfunction

  function automatic logic [9:0] sat_inc(logic [9:0] v);
    return (v == 10'h3FF) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_tracker.sv
// Recovers raster position from registered hsync/vsync, checks line and frame lengths,
// and maintains the lock counter.
module vga_sync_tracker #(
  parameter int HPIXELS_P     = vga_timing_pkg::HPIXELS,
  parameter int VLINES_P      = vga_timing_pkg::VLINES,
  parameter int LOCK_FRAMES_P = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       dclk_i,
  input  logic       clr_i,
  input  logic       hsync_i,
  input  logic       vsync_i,
  output logic [9:0] rx_hc_o,
  output logic [9:0] rx_vc_o,
  output logic       locked_o,
  output logic       sync_err_o
);
  import vga_timing_pkg::*;

  logic       hs_prev_q, vs_prev_q;
  logic       vfell_q, vfell_d;
  logic [9:0] hc_q, hc_d, vc_q, vc_d;
  logic       line_seen_q, frame_seen_q;
  logic       frame_bad_q, frame_bad_d;
  logic [1:0] lock_cnt_q, lock_cnt_d;
  logic       locked_q, sync_err_q;
  logic       vfall, line_start, frame_start, line_bad, frame_err;

  always_comb begin
    // NOTE: each next-state value gets a default before any conditional override so no path leaves it unassigned (no latch).
    vc_d        = vc_q;
    lock_cnt_d  = lock_cnt_q;
    vfall       = vs_prev_q & ~vsync_i;
    line_start  = hs_prev_q & ~hsync_i;
    frame_start = line_start & (vfell_q | vfall);
    hc_d        = line_start ? 10'd0 : sat_inc(hc_q);
    if (frame_start)     vc_d = 10'd0;
    else if (line_start) vc_d = sat_inc(vc_q);
    vfell_d     = line_start ? 1'b0 : (vfell_q | vfall);
    line_bad    = line_start & line_seen_q & (hc_q != 10'(HPIXELS_P - 1));
    // A bad closing line on the frame-start sample still condemns the frame it ended.
    frame_err   = frame_start & frame_seen_q &
                  ((vc_q != 10'(VLINES_P - 1)) | frame_bad_q | line_bad);
    frame_bad_d = frame_start ? 1'b0 : (frame_bad_q | line_bad);
    if (frame_err)
      lock_cnt_d = 2'd0;
    else if (frame_start && frame_seen_q && lock_cnt_q != 2'd3)
      lock_cnt_d = lock_cnt_q + 2'd1;
  end

  always_ff @(posedge dclk_i or posedge clr_i) begin
    if (clr_i) begin
      hs_prev_q    <= 1'b1;
      vs_prev_q    <= 1'b1;
      vfell_q      <= 1'b0;
      hc_q         <= 10'h3FF;
      vc_q         <= 10'h3FF;
      line_seen_q  <= 1'b0;
      frame_seen_q <= 1'b0;
      frame_bad_q  <= 1'b0;
      lock_cnt_q   <= 2'd0;
      locked_q     <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      hs_prev_q    <= hsync_i;
      vs_prev_q    <= vsync_i;
      vfell_q      <= vfell_d;
      hc_q         <= hc_d;
      vc_q         <= vc_d;
      line_seen_q  <= line_seen_q | line_start;
      frame_seen_q <= frame_seen_q | frame_start;
      frame_bad_q  <= frame_bad_d;
      lock_cnt_q   <= lock_cnt_d;
      locked_q     <= (lock_cnt_d >= 2'(LOCK_FRAMES_P));
      sync_err_q   <= line_bad | frame_err;
    end
  end

  assign rx_hc_o    = hc_d;
  assign rx_vc_o    = vc_d;
  assign locked_o   = locked_q;
  assign sync_err_o = sync_err_q;

endmodule

// File: rtl/vga_frame_capture.sv
// VGA receive side: samples the centre pixel of each of the 8x8 cells, thresholds it
// and publishes the rebuilt 64-bit image once per frame.
module vga_frame_capture #(
  parameter int HPIXELS_P     = vga_timing_pkg::HPIXELS,
  parameter int VLINES_P      = vga_timing_pkg::VLINES,
  parameter int HBP_P         = vga_timing_pkg::HBP,
  parameter int VBP_P         = vga_timing_pkg::VBP,
  parameter int CELL_W_P      = vga_timing_pkg::CELL_W,
  parameter int CELL_H_P      = vga_timing_pkg::CELL_H,
  parameter int LUM_THRESH_P  = vga_timing_pkg::LUM_THRESH,
  parameter int LOCK_FRAMES_P = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        dclk_i,
  input  logic        clr_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic [2:0]  red_i,
  input  logic [2:0]  green_i,
  input  logic [1:0]  blue_i,
  output logic [63:0] im_o,
  output logic        im_valid_o,
  output logic        locked_o,
  output logic        sync_err_o
);
  import vga_timing_pkg::*;

  logic        hs_q, vs_q;
  pixel_t      pix_q;
  logic [9:0]  rx_hc, rx_vc;
  logic        locked;
  logic        hit_x, hit_y, hit, last, pix_bit;
  logic [2:0]  cx, cy;
  logic [5:0]  idx;
  logic [63:0] shadow_q, im_q;
  logic        im_valid_q;

  always_ff @(posedge dclk_i or posedge clr_i) begin
    if (clr_i) begin
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      pix_q <= '0;
    end else begin
      hs_q  <= hsync_i;
      vs_q  <= vsync_i;
      pix_q <= pixel_t'({red_i, green_i, blue_i});
    end
  end

  vga_sync_tracker #(
    .HPIXELS_P     (HPIXELS_P),
    .VLINES_P      (VLINES_P),
    .LOCK_FRAMES_P (LOCK_FRAMES_P)
  ) u_tracker (
    .dclk_i     (dclk_i),
    .clr_i      (clr_i),
    .hsync_i    (hs_q),
    .vsync_i    (vs_q),
    .rx_hc_o    (rx_hc),
    .rx_vc_o    (rx_vc),
    .locked_o   (locked),
    .sync_err_o (sync_err_o)
  );

  always_comb begin
    hit_x = 1'b0;
    hit_y = 1'b0;
    cx    = 3'd0;
    cy    = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (rx_hc == 10'(HBP_P + CELL_W_P * i + CELL_W_P / 2)) begin
        hit_x = 1'b1;
        cx    = 3'(i);
      end
      if (rx_vc == 10'(VBP_P + CELL_H_P * i + CELL_H_P / 2)) begin
        hit_y = 1'b1;
        cy    = 3'(i);
      end
    end
  end

  assign idx     = cell_idx(cx, cy);
  assign hit     = hit_x & hit_y;
  assign last    = hit & (idx == 6'd63);
  assign pix_bit = (luminance(pix_q) >= 5'(LUM_THRESH_P));

  always_ff @(posedge dclk_i or posedge clr_i) begin
    if (clr_i) begin
      // NOTE: the shadow is reset too, so a partial frame after clr never leaks stale cells into im.
      shadow_q   <= '0;
      im_q       <= '0;
      im_valid_q <= 1'b0;
    end else begin
      if (hit) shadow_q[idx] <= pix_bit;
      // Cell 63 is still in flight, so it bypasses the shadow straight into im.
      if (last) im_q <= {pix_bit, shadow_q[62:0]};
      im_valid_q <= last & locked;
    end
  end

  assign im_o       = im_q;
  assign im_valid_o = im_valid_q;
  assign locked_o   = locked;

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a shrunken raster (40x30 cycles, 4x3 cells).
module tb_vga_frame_capture;

  localparam int HP  = 40;
  localparam int VL  = 30;
  localparam int HPW = 4;
  localparam int VPW = 1;
  localparam int HB  = 6;
  localparam int VB  = 3;
  localparam int CW  = 4;
  localparam int CH  = 3;
  localparam int C63_H = HB + 7 * CW + CW / 2;
  localparam int C63_V = VB + 7 * CH + CH / 2;
  localparam logic [63:0] PAT = 64'hAA55_AA55_AA55_AA55;

  logic        dclk = 1'b0;
  logic        clr, hsync, vsync;
  logic [2:0]  red, green;
  logic [1:0]  blue;
  logic [63:0] im;
  logic        im_valid, locked, sync_err;

  always #5 dclk = ~dclk;

  vga_frame_capture #(
    .HPIXELS_P(HP), .VLINES_P(VL), .HBP_P(HB), .VBP_P(VB),
    .CELL_W_P(CW), .CELL_H_P(CH), .LUM_THRESH_P(12), .LOCK_FRAMES_P(2)
  ) dut (
    .dclk_i     (dclk),
    .clr_i      (clr),
    .hsync_i    (hsync),
    .vsync_i    (vsync),
    .red_i      (red),
    .green_i    (green),
    .blue_i     (blue),
    .im_o       (im),
    .im_valid_o (im_valid),
    .locked_o   (locked),
    .sync_err_o (sync_err)
  );

  typedef struct {
    int          nlines;
    int          short_vc;
    int          chg_vc;
    logic [63:0] new_src;
    logic        ovr_en;
    logic [7:0]  ovr_pix;
    int          clr_vc;
    logic        exp_locked;
    int          exp_valid;
    int          exp_err;
    logic [63:0] exp_im;
  } vec_t;

  vec_t        vecs[19];
  int          total, bad;
  int          nc, nc_63, valid_nc, valid_cnt, err_cnt;
  logic [63:0] src;
  logic        ovr_en;
  logic [7:0]  ovr_pix;
  logic [63:0] snap_im;
  logic        snap_valid, snap_locked, snap_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(int nl, int sh, int chg, logic [63:0] ns, logic oe,
                              logic [7:0] op, int cv, logic el, int ev, int ee,
                              logic [63:0] ei);
    vec_t v;
    v.nlines = nl; v.short_vc = sh; v.chg_vc = chg; v.new_src = ns;
    v.ovr_en = oe; v.ovr_pix = op; v.clr_vc = cv;
    v.exp_locked = el; v.exp_valid = ev; v.exp_err = ee; v.exp_im = ei;
    return v;
  endfunction

  // Source pixel as the display driver would emit it: white/black per cell, or a single probe pixel.
  function automatic logic [7:0] pix_at(int hc, int vc);
    logic [7:0] p;
    p = 8'h00;
    if (ovr_en) begin
      if (hc == HB + CW / 2 && vc == VB + CH / 2) p = ovr_pix;
    end else if (hc >= HB && hc < HB + 8 * CW && vc >= VB && vc < VB + 8 * CH) begin
      if (src[((hc - HB) / CW) + 8 * ((vc - VB) / CH)]) p = 8'hFF;
    end
    return p;
  endfunction

  task automatic step(input logic hs, input logic vs, input logic [7:0] pix);
    @(negedge dclk);
    nc++;
    if (im_valid === 1'b1) begin
      valid_cnt++;
      valid_nc = nc;
    end
    if (sync_err === 1'b1) err_cnt++;
    hsync = hs;
    vsync = vs;
    {red, green, blue} = pix;
  endtask

  task automatic drive_frame(input vec_t v);
    ovr_en  = v.ovr_en;
    ovr_pix = v.ovr_pix;
    for (int vc = 0; vc < v.nlines; vc++) begin
      if (vc == v.chg_vc) src = v.new_src;
      for (int hc = 0; hc < ((vc == v.short_vc) ? HP - 1 : HP); hc++) begin
        step(hc >= HPW, vc >= VPW, pix_at(hc, vc));
        if (hc == C63_H && vc == C63_V) nc_63 = nc;
        if (vc == v.clr_vc) begin
          if (hc == 0) clr = 1'b1;
          else if (hc == 1) begin
            snap_im = im; snap_valid = im_valid; snap_locked = locked; snap_err = sync_err;
          end else if (hc == 8) clr = 1'b0;
        end
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; nc = 0; nc_63 = 0; valid_nc = 0; valid_cnt = 0; err_cnt = 0;
    clr = 1'b1; hsync = 1'b1; vsync = 1'b1; red = '0; green = '0; blue = '0;
    src = PAT; ovr_en = 1'b0; ovr_pix = 8'h00;
    snap_im = '1; snap_valid = 1'b1; snap_locked = 1'b1; snap_err = 1'b1;

    //               lines short chg  new_src  ovr  pix    clr  lock val err im
    vecs[0]  = mk(VL, -1, -1, PAT,   1'b0, 8'h00, -1, 1'b0, 0, 0, PAT);
    vecs[1]  = mk(VL, -1, -1, PAT,   1'b0, 8'h00, -1, 1'b0, 0, 0, PAT);
    vecs[2]  = mk(VL, -1, -1, PAT,   1'b0, 8'h00, -1, 1'b1, 1, 0, PAT);
    vecs[3]  = mk(VL, -1, 11, 64'h1, 1'b0, 8'h00, -1, 1'b1, 1, 0, 64'h0000_0000_0055_AA55);
    vecs[4]  = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b1, 1, 0, 64'h1);
    vecs[5]  = mk(VL, 15, -1, 64'h1, 1'b0, 8'h00, -1, 1'b1, 1, 1, 64'h1);
    vecs[6]  = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b0, 0, 1, 64'h1);
    vecs[7]  = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b0, 0, 0, 64'h1);
    vecs[8]  = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b1, 1, 0, 64'h1);
    vecs[9]  = mk(VL - 1, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b1, 1, 0, 64'h1);
    vecs[10] = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b0, 0, 1, 64'h1);
    vecs[11] = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b0, 0, 0, 64'h1);
    vecs[12] = mk(VL, -1, -1, 64'h1, 1'b0, 8'h00, -1, 1'b1, 1, 0, 64'h1);
    vecs[13] = mk(VL, -1, -1, 64'h1, 1'b1, 8'hF0, -1, 1'b1, 1, 0, 64'h0);
    vecs[14] = mk(VL, -1, -1, 64'h1, 1'b1, 8'hED, -1, 1'b1, 1, 0, 64'h1);
    vecs[15] = mk(VL, -1,  0, PAT,   1'b0, 8'h00, 12, 1'b0, 0, 0, 64'h0);
    vecs[16] = mk(VL, -1, -1, PAT,   1'b0, 8'h00, -1, 1'b0, 0, 0, PAT);
    vecs[17] = mk(VL, -1, -1, PAT,   1'b0, 8'h00, -1, 1'b0, 0, 0, PAT);
    vecs[18] = mk(VL, -1, -1, PAT,   1'b0, 8'h00, -1, 1'b1, 1, 0, PAT);

    repeat (4) step(1'b1, 1'b1, 8'h00);
    check("reset im",       im,       64'h0);
    check("reset im_valid", im_valid, 64'h0);
    check("reset locked",   locked,   64'h0);
    check("reset sync_err", sync_err, 64'h0);
    clr = 1'b0;
    repeat (3) step(1'b1, 1'b1, 8'h00);

    for (int i = 0; i < 19; i++) begin
      valid_cnt = 0;
      err_cnt   = 0;
      valid_nc  = -1000;
      drive_frame(vecs[i]);
      check($sformatf("row%0d locked", i),   locked,         vecs[i].exp_locked);
      check($sformatf("row%0d im_valid", i), 64'(valid_cnt), 64'(vecs[i].exp_valid));
      check($sformatf("row%0d sync_err", i), 64'(err_cnt),   64'(vecs[i].exp_err));
      check($sformatf("row%0d im", i),       im,             vecs[i].exp_im);
      if (vecs[i].exp_valid == 1)
        check($sformatf("row%0d latency", i), 64'(valid_nc - nc_63), 64'd2);
    end

    check("clr im",       snap_im,     64'h0);
    check("clr im_valid", snap_valid,  64'h0);
    check("clr locked",   snap_locked, 64'h0);
    check("clr sync_err", snap_err,    64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
